// File: rtl/fifo_rr_scheduler.sv
// Purpose : round-robin drain of NUM_FIFOS show-ahead-less FIFOs into one in-order output stream.
// Latency : 2 cycles from fifo_rdreq to out_valid; one word per cycle sustained.
// Backpressure: reads stop once buffered + in-flight words would exceed the 2-entry output buffer.
//
// Ports:
//   clock, rst           single clock, asynchronous active-high reset
//   fifo_empty/fifo_en   per-FIFO empty flag and eligibility mask
//   fifo_q               packed read data, FIFO i at [i*DWIDTH +: DWIDTH], valid 1 cycle after rdreq
//   fifo_rdreq           one-hot read request (combinational)
//   out_valid/out_ready  output handshake; out_data/out_id carry the word and its source FIFO
module fifo_rr_scheduler #(
  parameter int NUM_FIFOS = 4,
  parameter int DWIDTH    = 8,
  parameter int ID_W      = $clog2(NUM_FIFOS)
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [NUM_FIFOS-1:0]        fifo_empty,
  input  logic [NUM_FIFOS*DWIDTH-1:0] fifo_q,
  output logic [NUM_FIFOS-1:0]        fifo_rdreq,
  input  logic [NUM_FIFOS-1:0]        fifo_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DWIDTH-1:0]           out_data,
  output logic [ID_W-1:0]             out_id
);

  logic [NUM_FIFOS-1:0] eligible;
  logic                 pop;
  logic                 issue;
  logic                 arrive;
  logic                 found;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      ptr_next;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      infl_id;
  logic                 inflight;
  logic [1:0]           count;
  logic [2:0]           occ_after_pop;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [DWIDTH-1:0]    arrive_data;
  logic [DWIDTH-1:0]    ob_data [2];
  logic [ID_W-1:0]      ob_id   [2];

  assign eligible  = fifo_en & ~fifo_empty;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // The FIFO returns data one cycle after the request, so an in-flight read always lands now.
  assign arrive    = inflight;
  assign out_data  = ob_data[rd_ptr];
  assign out_id    = ob_id[rd_ptr];

  // Space check counts the word already in flight and credits the word leaving this cycle,
  // which keeps one read per cycle going while the consumer drains.
  assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = ~rst & (|eligible) & (occ_after_pop < 3'd2);

  // First eligible index at or after ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!found && eligible[(int'(ptr) + k) % NUM_FIFOS]) begin
        grant = ID_W'((int'(ptr) + k) % NUM_FIFOS);
        found = 1'b1;
      end
    end
  end

  assign ptr_next = (grant == ID_W'(NUM_FIFOS - 1)) ? '0 : grant + ID_W'(1);

  always_comb begin
    fifo_rdreq = '0;
    if (issue) begin
      fifo_rdreq[grant] = 1'b1;
    end
  end

  assign arrive_data = fifo_q[int'(infl_id) * DWIDTH +: DWIDTH];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      inflight <= 1'b0;
      infl_id  <= '0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        ob_data[e] <= '0;
        ob_id[e]   <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        ptr     <= ptr_next;
        infl_id <= grant;
      end
      if (arrive) begin
        ob_data[wr_ptr] <= arrive_data;
        ob_id[wr_ptr]   <= infl_id;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, arrive} - {1'b0, pop};
    end
  end

  // Buffer plus in-flight read can never exceed the two buffer slots.
  a_no_overflow : assert property (@(posedge clock) disable iff (rst)
    ({1'b0, count} + {2'b00, inflight}) <= 3'd2);

  // A request only ever targets an enabled, non-empty FIFO.
  a_rdreq_eligible : assert property (@(posedge clock) disable iff (rst)
    (fifo_rdreq & ~eligible) == '0);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Purpose : directed + random check of fifo_rr_scheduler against a queue-based model.
// Latency : model expects words visible 2 cycles after their read request.
// Backpressure: model allows a read only while held + pending words stay below 2.
module tb_fifo_rr_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            rst;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_q;
  logic [N-1:0]    fifo_rdreq;
  logic [N-1:0]    fifo_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  fifo_rr_scheduler #(.NUM_FIFOS(N), .DWIDTH(DW), .ID_W(IW)) dut (
    .clock(clock), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .fifo_en(fifo_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } ent_t;

  logic [DW-1:0] fq [N][$];   // contents of each source FIFO
  int            wseq [N];
  int            push_n [N];
  logic [N-1:0]  rd_s;
  ent_t          mq [$];      // words read but not yet consumed, oldest first
  int            mptr;
  int            cyc;
  int            total;
  int            bad;
  logic [N-1:0]  rd_log [$];
  int            rd_cyc [$];
  int            got_id [$];
  int            pop_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Runs at the falling edge: compares DUT outputs with the model, then advances the model.
  task automatic check_cycle();
    logic [N-1:0] elig;
    logic [N-1:0] exp_rd;
    logic         vis;
    logic         pop;
    logic         issue;
    int           g;
    elig = fifo_en & ~fifo_empty;
    rd_s = fifo_rdreq;
    if (rst) begin
      mq.delete();
      mptr = 0;
      chk("rst_rdreq", 32'(fifo_rdreq), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_id", 32'(out_id), 0);
    end else begin
      vis   = (mq.size() > 0) && (mq[0].due <= cyc);
      pop   = vis && out_ready;
      issue = (elig != 0) && ((mq.size() - int'(pop)) < 2);
      exp_rd = '0;
      g = -1;
      if (issue) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && elig[(mptr + k) % N]) g = (mptr + k) % N;
        exp_rd[g] = 1'b1;
      end
      chk("rdreq", 32'(fifo_rdreq), 32'(exp_rd));
      chk("rdreq_on_ineligible", 32'(fifo_rdreq & ~elig), 0);
      chk("out_valid", 32'(out_valid), 32'(vis));
      if (vis) begin
        chk("out_data", 32'(out_data), 32'(mq[0].data));
        chk("out_id", 32'(out_id), 32'(mq[0].id));
      end
      if (fifo_rdreq != 0) begin
        rd_log.push_back(fifo_rdreq);
        rd_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_id.push_back(int'(out_id));
        pop_cyc.push_back(cyc);
      end
      if (pop) void'(mq.pop_front());
      if (issue) begin
        mq.push_back('{g, fq[g][0], cyc + 2});
        mptr = (g + 1) % N;
      end
    end
    cyc++;
  endtask

  // Source FIFO behaviour at the rising edge: read data appears one cycle after rdreq.
  task automatic fifo_update();
    logic [N*DW-1:0] qn;
    logic [N-1:0]    en_n;
    qn = fifo_q;
    for (int i = 0; i < N; i++)
      if (rd_s[i] && fq[i].size() > 0) qn[i*DW +: DW] = fq[i].pop_front();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < push_n[i]; p++) begin
        fq[i].push_back(8'(i * 64 + (wseq[i] % 64)));
        wseq[i]++;
      end
    for (int i = 0; i < N; i++) en_n[i] = (fq[i].size() == 0);
    fifo_q     <= qn;
    fifo_empty <= en_n;
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    fifo_update();
    #1;
    for (int i = 0; i < N; i++) push_n[i] = 0;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    rd_cyc.delete();
    got_id.delete();
    pop_cyc.delete();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int sz;
    total = 0; bad = 0; cyc = 0; mptr = 0;
    rst = 1'b1; out_ready = 1'b1; fifo_en = '1;
    fifo_empty = '1; fifo_q = '0; rd_s = '0;
    for (int i = 0; i < N; i++) begin push_n[i] = 0; wseq[i] = 0; end
    repeat (3) tick();
    rst = 1'b0;

    // All four FIFOs with 3 words, always ready: ids 0..3 repeating, back to back.
    clear_logs();
    for (int i = 0; i < N; i++) push_n[i] = 3;
    repeat (20) tick();
    chk("a_words", got_id.size(), 12);
    for (int k = 0; k < 12 && k < got_id.size(); k++) chk("a_id_seq", got_id[k], k % 4);
    if (got_id.size() == 12) chk("a_back_to_back", pop_cyc[11] - pop_cyc[0], 11);
    if (got_id.size() > 0 && rd_cyc.size() > 0) chk("a_latency", pop_cyc[0] - rd_cyc[0], 2);

    // Only FIFO 2 holds 5 words.
    reset_pulse();
    clear_logs();
    push_n[2] = 5;
    repeat (12) tick();
    chk("b_reads", rd_log.size(), 5);
    for (int k = 0; k < rd_log.size(); k++) chk("b_rdreq", 32'(rd_log[k]), 32'h4);
    if (rd_log.size() == 5) chk("b_consecutive", rd_cyc[4] - rd_cyc[0], 4);
    chk("b_words", got_id.size(), 5);
    for (int k = 0; k < got_id.size(); k++) chk("b_id", got_id[k], 2);

    // Consumer stalls for 10 cycles under full traffic.
    reset_pulse();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) push_n[i] = 3;
    repeat (11) tick();
    chk("c_stall_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("c_first_rd", 32'(rd_log[0]), 32'h1);
      chk("c_second_rd", 32'(rd_log[1]), 32'h2);
    end
    out_ready = 1'b1;
    repeat (20) tick();
    chk("c_words", got_id.size(), 12);
    for (int k = 0; k < 12 && k < got_id.size(); k++) chk("c_id_seq", got_id[k], k % 4);

    // Reset while a word is buffered and another is in flight.
    reset_pulse();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) push_n[i] = 3;
    repeat (3) tick();
    fifo_en = 4'b1100;
    rst = 1'b1;
    #1;
    chk("d_valid_async", 32'(out_valid), 0);
    chk("d_data_async", 32'(out_data), 0);
    tick();
    rst = 1'b0;
    clear_logs();
    out_ready = 1'b1;
    repeat (10) tick();
    if (rd_log.size() > 0) chk("d_first_grant", 32'(rd_log[0]), 32'h4);
    else chk("d_first_grant_missing", 0, 1);
    if (got_id.size() > 0) chk("d_first_word_id", got_id[0], 2);
    else chk("d_first_word_missing", 0, 1);
    fifo_en = '1;
    repeat (20) tick();

    // Random enables, writes and backpressure, then drain.
    for (int c = 0; c < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) fifo_en = 4'($urandom);
      for (int i = 0; i < N; i++)
        push_n[i] = (fq[i].size() < 6 && $urandom_range(0, 3) == 0) ? 1 : 0;
      tick();
    end
    fifo_en = '1;
    out_ready = 1'b1;
    repeat (40) tick();
    sz = 0;
    for (int i = 0; i < N; i++) sz += fq[i].size();
    chk("e_fifos_drained", sz, 0);
    chk("e_model_drained", mq.size(), 0);
    chk("e_out_idle", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
